fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage pipeline. Tracks destination-register state of the EX and MEM stages, drives the 2-bit select of each ID-stage operand forwarding mux (port A and port B), and generates pipeline stalls for load-use hazards. It also sequences the multi-cycle multiplier occupying EX. Sits beside the ID stage; its outputs feed the operand muxes, the PC/IF-ID write enables and the ID/EX, EX/MEM register controls.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 48 ++++
 rtl/fwd_hazard_ctrl_if.sv | 35 +++
 rtl/fwd_hazard_ctrl_mul_seq.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 65 ++++++
 tb/tb_fwd_hazard_ctrl.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types, select encodings and the operand-select helper for the
// forwarding/hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  typedef logic [1:0]       fwd_sel_t;
  typedef logic [REG_W-1:0] reg_num_t;

  localparam fwd_sel_t FWD_RF   = 2'b00;
  localparam fwd_sel_t FWD_EXR  = 2'b01;
  localparam fwd_sel_t FWD_MEMR = 2'b10;
  localparam fwd_sel_t FWD_MEMD = 2'b11;

  typedef struct packed {
    reg_num_t rn;
    logic     wreg;
    logic     m2reg;
    logic     mul;
  } ex_state_t;

  typedef struct packed {
    reg_num_t rn;
    logic     wreg;
    logic     m2reg;
  } mem_state_t;

  // A load sitting in EX has no data yet, so it falls through to the MEM check.
  function automatic fwd_sel_t fwd_select(
    input logic     use_src,
    input reg_num_t src,
    input reg_num_t e_rn,
    input logic     e_wreg,
    input logic     e_m2reg,
    input reg_num_t m_rn,
    input logic     m_wreg,
    input logic     m_m2reg
  );
    fwd_select = FWD_RF;
    if (use_src && (src != '0) && e_wreg && (e_rn == src) && !e_m2reg) begin
      fwd_select = FWD_EXR;
    end else if (m_wreg && (m_rn == src) && (src != '0)) begin
      fwd_select = m_m2reg ? FWD_MEMD : FWD_MEMR;
    end
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage side of the controller: decoded register fields in, mux selects
// and stall/bubble controls out.
interface fwd_hazard_ctrl_if;
  import fwd_hazard_ctrl_pkg::*;

  // No handshake: every output is a same-cycle combinational response to the
  // d_* fields, which the ID stage must hold steady while wpcir is 0.
  reg_num_t   d_rs;
  reg_num_t   d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  reg_num_t   d_rn;
  logic       d_wreg;
  logic       d_m2reg;
  logic       d_mul;

  fwd_sel_t   fwda;
  fwd_sel_t   fwdb;
  logic       wpcir;
  logic       e_hold;
  logic       e_bubble;
  logic       m_bubble;
  logic       mul_busy;
  logic [CNT_W-1:0] dbg_mul_cnt;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_rn, d_wreg, d_m2reg, d_mul,
    input  fwda, fwdb, wpcir, e_hold, e_bubble, m_bubble, mul_busy, dbg_mul_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_rn, d_wreg, d_m2reg, d_mul,
    output fwda, fwdb, wpcir, e_hold, e_bubble, m_bubble, mul_busy, dbg_mul_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_mul_seq.sv
// Counts the remaining EX cycles of a multiply; busy while a multiply sits
// in EX with cycles still to go.
module fwd_hazard_ctrl_mul_seq
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             i_e_mul,
  input  logic             i_advance,
  input  logic             i_d_mul,
  output logic             o_mul_busy,
  output logic [CNT_W-1:0] o_mul_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  logic [CNT_W-1:0] r_mul_cnt;
  logic             w_busy;

  assign w_busy     = i_e_mul && (r_mul_cnt != '0);
  assign o_mul_busy = w_busy;
  assign o_mul_cnt  = r_mul_cnt;

  // On a load-use stall the count is left alone; it is already 0 there.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_mul_cnt <= '0;
    end else if (w_busy) begin
      r_mul_cnt <= r_mul_cnt - 1'b1;
    end else if (i_advance) begin
      r_mul_cnt <= i_d_mul ? CNT_LOAD : '0;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and multiplier hold control for the
// 5-stage pipeline; tracks EX and MEM destination state.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               clrn,
  fwd_hazard_ctrl_if.slave   bus
);

  ex_state_t  r_e;
  mem_state_t r_m;

  logic w_ld_stall;
  logic w_mul_busy;
  logic w_advance;

  assign w_ld_stall = r_e.wreg && r_e.m2reg && (r_e.rn != '0) &&
                      ((bus.d_use_rs && (r_e.rn == bus.d_rs)) ||
                       (bus.d_use_rt && (r_e.rn == bus.d_rt)));

  assign w_advance = !w_mul_busy && !w_ld_stall;

  fwd_hazard_ctrl_mul_seq #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_seq (
    .clk        (clk),
    .clrn       (clrn),
    .i_e_mul    (r_e.mul),
    .i_advance  (w_advance),
    .i_d_mul    (bus.d_mul),
    .o_mul_busy (w_mul_busy),
    .o_mul_cnt  (bus.dbg_mul_cnt)
  );

  assign bus.fwda = fwd_select(bus.d_use_rs, bus.d_rs, r_e.rn, r_e.wreg, r_e.m2reg,
                               r_m.rn, r_m.wreg, r_m.m2reg);
  assign bus.fwdb = fwd_select(bus.d_use_rt, bus.d_rt, r_e.rn, r_e.wreg, r_e.m2reg,
                               r_m.rn, r_m.wreg, r_m.m2reg);

  // Multiplier busy dominates a load-use stall.
  assign bus.wpcir    = w_advance;
  assign bus.e_bubble = w_ld_stall && !w_mul_busy;
  assign bus.e_hold   = w_mul_busy;
  assign bus.m_bubble = w_mul_busy;
  assign bus.mul_busy = w_mul_busy;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_e <= '0;
      r_m <= '0;
    end else if (w_mul_busy) begin
      r_m <= '0;
    end else if (w_ld_stall) begin
      r_m <= '{rn: r_e.rn, wreg: r_e.wreg, m2reg: r_e.m2reg};
      r_e <= '0;
    end else begin
      r_m <= '{rn: r_e.rn, wreg: r_e.wreg, m2reg: r_e.m2reg};
      r_e <= '{rn: bus.d_rn, wreg: bus.d_wreg, m2reg: bus.d_m2reg, mul: bus.d_mul};
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: driver pushes hand-computed outputs into
// a queue, a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;
  import fwd_hazard_ctrl_pkg::*;

  localparam int W = 9;
  // {fwda, fwdb, wpcir, e_hold, e_bubble, m_bubble, mul_busy}
  localparam logic [W-1:0] X_IDLE = 9'b00_00_1_0_0_0_0;

  logic clk;
  logic clrn;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl #(
    .MUL_LAT (4)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // driver
  task automatic step(
    input logic [4:0]   rs,
    input logic [4:0]   rt,
    input logic         urs,
    input logic         urt,
    input logic [4:0]   rn,
    input logic         wreg,
    input logic         m2reg,
    input logic         mul,
    input logic         rst_n_val,
    input logic [W-1:0] exp,
    input string        name
  );
    @(posedge clk);
    #1;
    clrn         = rst_n_val;
    bus.d_rs     = rs;
    bus.d_rt     = rt;
    bus.d_use_rs = urs;
    bus.d_use_rt = urt;
    bus.d_rn     = rn;
    bus.d_wreg   = wreg;
    bus.d_m2reg  = m2reg;
    bus.d_mul    = mul;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {bus.fwda, bus.fwdb, bus.wpcir, bus.e_hold, bus.e_bubble,
               bus.m_bubble, bus.mul_busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got %b_%b_%b%b%b%b%b expected %b_%b_%b%b%b%b%b", nm,
                 got_v[8:7], got_v[6:5], got_v[4], got_v[3], got_v[2], got_v[1], got_v[0],
                 exp_v[8:7], exp_v[6:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    clrn         = 1'b0;
    bus.d_rs     = '0;
    bus.d_rt     = '0;
    bus.d_use_rs = 1'b0;
    bus.d_use_rt = 1'b0;
    bus.d_rn     = '0;
    bus.d_wreg   = 1'b0;
    bus.d_m2reg  = 1'b0;
    bus.d_mul    = 1'b0;

    //    rs  rt  urs urt rn  wr  m2r mul rst  expected             name
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, X_IDLE,               "reset_state");
    step(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 1, X_IDLE,               "issue_add3");
    step(5'd3, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 9'b01_00_1_0_0_0_0,   "ex_fwd_a");
    step(5'd6, 5'd3, 1, 1, 5'd0, 0, 0, 0, 1, 9'b01_10_1_0_0_0_0,   "ex_a_mem_alu_b");
    step(5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 1, X_IDLE,               "issue_lw5");
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, X_IDLE,               "nop_no_use");
    step(5'd0, 5'd5, 0, 1, 5'd0, 0, 0, 0, 1, 9'b00_11_1_0_0_0_0,   "mem_load_b");
    step(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 1, X_IDLE,               "issue_add5");
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, X_IDLE,               "nop_add5_in_ex");
    step(5'd0, 5'd5, 0, 1, 5'd0, 0, 0, 0, 1, 9'b00_10_1_0_0_0_0,   "mem_alu_b");
    step(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 1, X_IDLE,               "issue_add5_first");
    step(5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0, 1, X_IDLE,               "issue_add5_second");
    step(5'd5, 5'd5, 1, 1, 5'd0, 0, 0, 0, 1, 9'b01_01_1_0_0_0_0,   "ex_over_mem");
    step(5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 1, X_IDLE,               "issue_lw4");
    step(5'd4, 5'd0, 1, 0, 5'd8, 1, 0, 0, 1, 9'b00_00_0_0_1_0_0,   "load_use_stall");
    step(5'd4, 5'd0, 1, 0, 5'd8, 1, 0, 0, 1, 9'b11_00_1_0_0_0_0,   "load_use_fwd");
    step(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 1, X_IDLE,               "issue_lw0");
    step(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 1, X_IDLE,               "zero_no_stall");
    step(5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 1, 1, X_IDLE,               "issue_mul7");
    step(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, 9'b01_00_0_1_0_1_1,   "mul_busy_3");
    step(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, 9'b01_00_0_1_0_1_1,   "mul_busy_2");
    step(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, 9'b01_00_0_1_0_1_1,   "mul_busy_1");
    step(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, 9'b01_00_1_0_0_0_0,   "mul_done_fwd");
    step(5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 1, 1, X_IDLE,              "issue_mul10");
    step(5'd10, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, 9'b01_00_0_1_0_1_1,  "mul10_busy_3");
    step(5'd10, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, X_IDLE,              "reset_mid_mul");
    step(5'd10, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, X_IDLE,              "reset_held");
    step(5'd10, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, X_IDLE,              "after_reset");
    step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, X_IDLE,               "after_reset_idle");

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
